// File: rtl/dct_row_butterfly_if.sv
// Pixel input handshake and butterfly result bus of the row-DCT front end.
// The slave side is the butterfly block; the master side feeds pixels and consumes rows.
interface dct_row_butterfly_if #(
    parameter int WIDTH = 8
);
    logic                    In_Valid;
    logic                    In_Ready;
    logic [WIDTH-1:0]        In_Pixel;
    logic                    Out_Valid;
    logic [2:0]              Out_Row_Index;
    logic                    Out_Block_Last;
    logic signed [WIDTH+1:0] Out_Data_0;
    logic signed [WIDTH+1:0] Out_Data_1;
    logic signed [WIDTH+1:0] Out_Data_2;
    logic signed [WIDTH+1:0] Out_Data_3;
    logic signed [WIDTH+1:0] Out_Data_4;
    logic signed [WIDTH+1:0] Out_Data_5;
    logic signed [WIDTH+1:0] Out_Data_6;
    logic signed [WIDTH+1:0] Out_Data_7;

    modport slave (
        input  In_Valid, In_Pixel,
        output In_Ready, Out_Valid, Out_Row_Index, Out_Block_Last,
        output Out_Data_0, Out_Data_1, Out_Data_2, Out_Data_3,
        output Out_Data_4, Out_Data_5, Out_Data_6, Out_Data_7
    );

    modport master (
        output In_Valid, In_Pixel,
        input  In_Ready, Out_Valid, Out_Row_Index, Out_Block_Last,
        input  Out_Data_0, Out_Data_1, Out_Data_2, Out_Data_3,
        input  Out_Data_4, Out_Data_5, Out_Data_6, Out_Data_7
    );
endinterface

// File: rtl/dct_row_butterfly.sv
// Row-DCT front end: level-shifts eight pixels of a row and registers the first butterfly
// (mirrored sums and differences), tagging each row with its index inside the 8x8 block.
module dct_row_butterfly #(
    parameter int WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Clear,
    dct_row_butterfly_if.slave bus
);
    typedef enum logic {ST_HALT, ST_RUN} state_t;

    localparam logic [WIDTH:0] OFFSET = (WIDTH+1)'(1) << (WIDTH-1);

    state_t                  state;
    state_t                  state_next;
    logic                    in_ready;
    logic                    accept;
    logic                    row_done;
    logic [2:0]              col;
    logic [2:0]              row;
    logic                    valid_q;
    logic [2:0]              row_index_q;
    logic signed [WIDTH:0]   shifted;
    logic signed [WIDTH:0]   buffer [0:6];
    logic signed [WIDTH:0]   sample [8];
    logic signed [WIDTH+1:0] bfly   [8];
    logic signed [WIDTH+1:0] data_q [8];

    // Ready is held low while in reset and comes up on the first edge after it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_HALT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_HALT: state_next = ST_RUN;
            ST_RUN:  in_ready   = 1'b1;
            default: state_next = ST_HALT;
        endcase
    end

    // Clear discards whatever pixel arrives with it, so it never counts as accepted.
    assign accept   = bus.In_Valid & in_ready & ~Clear;
    assign row_done = accept & (col == 3'd7);
    assign shifted  = {1'b0, bus.In_Pixel} - OFFSET;

    always_ff @(posedge Clock) begin
        if (accept && (col != 3'd7)) begin
            buffer[col] <= shifted;
        end
    end

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            sample[i] = buffer[i];
        end
        sample[7] = shifted;
    end

    // Operands are sign-extended by one bit so sums and differences are exact.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            bfly[2*k]   = {sample[k][WIDTH], sample[k]} + {sample[7-k][WIDTH], sample[7-k]};
            bfly[2*k+1] = {sample[k][WIDTH], sample[k]} - {sample[7-k][WIDTH], sample[7-k]};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            col         <= '0;
            row         <= '0;
            valid_q     <= 1'b0;
            row_index_q <= '0;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= row_done;
            if (Clear) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                col <= col + 3'd1;
                if (col == 3'd7) begin
                    row_index_q <= row;
                    row         <= row + 3'd1;
                    for (int k = 0; k < 8; k++) begin
                        data_q[k] <= bfly[k];
                    end
                end
            end
        end
    end

    assign bus.In_Ready       = in_ready;
    assign bus.Out_Valid      = valid_q;
    assign bus.Out_Row_Index  = row_index_q;
    assign bus.Out_Block_Last = valid_q & (row_index_q == 3'd7);
    assign bus.Out_Data_0     = data_q[0];
    assign bus.Out_Data_1     = data_q[1];
    assign bus.Out_Data_2     = data_q[2];
    assign bus.Out_Data_3     = data_q[3];
    assign bus.Out_Data_4     = data_q[4];
    assign bus.Out_Data_5     = data_q[5];
    assign bus.Out_Data_6     = data_q[6];
    assign bus.Out_Data_7     = data_q[7];
endmodule

// File: tb/tb_dct_row_butterfly.sv
// Scoreboard bench for dct_row_butterfly: stimulus pushes expected rows, a negedge monitor pops
// and compares them whenever Out_Valid is seen.
module tb_dct_row_butterfly;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0][9:0] data;
        logic [2:0]      idx;
        logic            last;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;
    logic Clear;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q [$];

    always #5 Clock = ~Clock;

    dct_row_butterfly_if #(.WIDTH(WIDTH)) bus ();

    dct_row_butterfly #(.WIDTH(WIDTH)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Clear),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Expected rows from the stream are derived from the pixel values with a small model.
    function automatic exp_t model(input int px[8], input int idx);
        exp_t e;
        int   s[8];
        for (int i = 0; i < 8; i++) s[i] = px[i] - 128;
        for (int k = 0; k < 4; k++) begin
            e.data[2*k]   = 10'(s[k] + s[7-k]);
            e.data[2*k+1] = 10'(s[k] - s[7-k]);
        end
        e.idx  = 3'(idx);
        e.last = (idx == 7);
        return e;
    endfunction

    task automatic pushHand(input int d[8], input int idx);
        exp_t e;
        for (int k = 0; k < 8; k++) e.data[k] = 10'(d[k]);
        e.idx  = 3'(idx);
        e.last = (idx == 7);
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input int pixel, input bit clr);
        bus.In_Valid = 1'b1;
        bus.In_Pixel = 8'(pixel);
        Clear        = clr;
        @(posedge Clock);
        #1;
        bus.In_Valid = 1'b0;
        Clear        = 1'b0;
    endtask

    task automatic sendRow(input int px[8]);
        for (int i = 0; i < 8; i++) applyStimulus(px[i], 1'b0);
    endtask

    task automatic pulseClear();
        Clear = 1'b1;
        @(posedge Clock);
        #1;
        Clear = 1'b0;
    endtask

    // Monitor: one pop per cycle of Out_Valid, so a stretched pulse shows up as an extra row.
    always @(negedge Clock) begin
        logic signed [9:0] got [8];
        exp_t e;
        if (bus.Out_Valid === 1'b1) begin
            got[0] = bus.Out_Data_0; got[1] = bus.Out_Data_1;
            got[2] = bus.Out_Data_2; got[3] = bus.Out_Data_3;
            got[4] = bus.Out_Data_4; got[5] = bus.Out_Data_5;
            got[6] = bus.Out_Data_6; got[7] = bus.Out_Data_7;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                for (int k = 0; k < 8; k++)
                    checkOutput($sformatf("out_data_%0d", k), int'(got[k]), int'($signed(e.data[k])));
                checkOutput("out_row_index", int'(bus.Out_Row_Index), int'(e.idx));
                checkOutput("out_block_last", int'(bus.Out_Block_Last), int'(e.last));
            end
        end else begin
            checkOutput("block_last_idle", int'(bus.Out_Block_Last), 0);
        end
    end

    initial begin
        int px[8];
        Reset        = 1'b1;
        Clear        = 1'b0;
        bus.In_Valid = 1'b0;
        bus.In_Pixel = '0;
        #12;
        checkOutput("reset_in_ready", int'(bus.In_Ready), 0);
        checkOutput("reset_out_valid", int'(bus.Out_Valid), 0);
        checkOutput("reset_row_index", int'(bus.Out_Row_Index), 0);
        checkOutput("reset_data_0", int'(bus.Out_Data_0), 0);
        checkOutput("reset_data_7", int'(bus.Out_Data_7), 0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkOutput("ready_before_edge", int'(bus.In_Ready), 0);
        @(posedge Clock);
        #1;
        checkOutput("ready_after_edge", int'(bus.In_Ready), 1);

        pushHand('{0, 0, 0, 0, 0, 0, 0, 0}, 0);
        sendRow('{128, 128, 128, 128, 128, 128, 128, 128});
        pushHand('{-249, -7, -248, -6, -249, -3, -249, -1}, 1);
        sendRow('{0, 1, 2, 3, 4, 5, 7, 7});
        pushHand('{-1, 255, -256, 0, -256, 0, -256, 0}, 2);
        sendRow('{255, 0, 0, 0, 0, 0, 0, 0});
        pushHand('{-1, -255, -256, 0, -256, 0, -256, 0}, 3);
        sendRow('{0, 0, 0, 0, 0, 0, 0, 255});

        // Full block of rows with random idle gaps, plus one row past the wrap.
        pulseClear();
        for (int r = 0; r < 9; r++) begin
            for (int i = 0; i < 8; i++) px[i] = int'($urandom_range(0, 255));
            exp_q.push_back(model(px, r % 8));
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge Clock);
                #1;
                applyStimulus(px[i], 1'b0);
            end
        end

        for (int i = 0; i < 5; i++) applyStimulus(17 * i, 1'b0);
        pulseClear();
        pushHand('{144, 0, 144, 0, 144, 0, 144, 0}, 0);
        sendRow('{200, 200, 200, 200, 200, 200, 200, 200});

        // Clear together with the column-7 pixel must drop the row entirely.
        for (int i = 0; i < 7; i++) applyStimulus(90, 1'b0);
        applyStimulus(90, 1'b1);
        repeat (3) @(posedge Clock);
        #1;
        pushHand('{-166, -70, -166, -50, -166, -30, -166, -10}, 0);
        sendRow('{10, 20, 30, 40, 50, 60, 70, 80});
        repeat (3) @(posedge Clock);
        #1;

        for (int i = 0; i < 3; i++) applyStimulus(33, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("midrow_reset_data_0", int'(bus.Out_Data_0), 0);
        checkOutput("midrow_reset_data_1", int'(bus.Out_Data_1), 0);
        checkOutput("midrow_reset_in_ready", int'(bus.In_Ready), 0);
        checkOutput("midrow_reset_out_valid", int'(bus.Out_Valid), 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        pushHand('{-128, 128, 0, 0, 0, 0, 0, 0}, 0);
        sendRow('{128, 128, 128, 128, 128, 128, 128, 0});

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge Clock);
        repeat (2) @(posedge Clock);
        checkOutput("rows_outstanding", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
